riscv_pmp_access_gate: RTL and testbench

- Request-holding stage directly upstream of the PMP checker, between the memory access unit and the BIU.
- Accepts one physical-address access at a time and presents it to the PMP checker. The checker has a one-cycle registered latency, so the gate freezes the checker with stall while it waits for the verdict.
- On a clean verdict the access is forwarded to the BIU. On a violation it is dropped and an access-fault with cause code and trap address is reported.

---
 rtl/riscv_pmp_access_gate.sv | 204 ++++++++++++++++++++
 tb/tb_riscv_pmp_access_gate.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pmp_access_gate.sv
// ---------------------------------------------------------------------------
// riscv_pmp_access_gate
//
// Request-holding stage between the memory access unit and the BIU, placed
// directly upstream of the PMP checker. It accepts one physical-address
// access at a time and presents it to the PMP checker. The checker returns
// its verdict one cycle later, so the checker is stalled while the gate
// waits. A clean access is forwarded to the BIU. A violating access is
// dropped and reported as an access fault.
//
// Ports
//   clk_i, rst_ni            core clock, asynchronous active-low reset
//   flush_i                  pipeline flush, aborts a pending access
//   req_i, adr_i, size_i,
//   we_i, instruction_i, d_i access request from the memory access unit
//   ack_o                    request accepted this cycle
//   pmp_*_o                  access presented to the PMP checker
//   pmp_stall_o              freezes the PMP checker while an access is held
//   pmp_exception_i          PMP verdict, one cycle after presentation
//   biu_*_o, biu_ack_i       request towards the bus interface unit
//   done_o                   one-cycle pulse, access issued to the BIU
//   fault_o                  one-cycle pulse, PMP access fault
//   fault_cause_o            1 = instruction, 5 = load, 7 = store/AMO fault
//   fault_adr_o              faulting address (trap value)
// ---------------------------------------------------------------------------
package riscv_pmp_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;
endpackage

module riscv_pmp_access_gate
    import riscv_pmp_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PLEN = (XLEN == 32) ? 34 : 56
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            req_i,
    input  logic [PLEN-1:0] adr_i,
    input  biu_size_t       size_i,
    input  logic            we_i,
    input  logic            instruction_i,
    input  logic [XLEN-1:0] d_i,
    output logic            ack_o,
    output logic [PLEN-1:0] pmp_adr_o,
    output biu_size_t       pmp_size_o,
    output logic            pmp_we_o,
    output logic            pmp_instruction_o,
    output logic            pmp_stall_o,
    input  logic            pmp_exception_i,
    output logic            biu_req_o,
    output logic [PLEN-1:0] biu_adr_o,
    output biu_size_t       biu_size_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic            biu_ack_i,
    output logic            done_o,
    output logic            fault_o,
    output logic [3:0]      fault_cause_o,
    output logic [PLEN-1:0] fault_adr_o
);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, FAULT} state_e;

    state_e          state_q, state_d;
    logic [PLEN-1:0] adr_q, adr_d;
    biu_size_t       size_q, size_d;
    logic            we_q, we_d;
    logic            instr_q, instr_d;
    logic [XLEN-1:0] d_q, d_d;
    logic            flushed_q, flushed_d;
    logic            done_q, done_d;
    logic [3:0]      cause_q, cause_d;
    logic [PLEN-1:0] fault_adr_q, fault_adr_d;

    logic accept;

    assign ack_o  = (state_q == IDLE) && !flush_i;
    assign accept = req_i && ack_o;

    // Next-state and holding-register update.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        adr_d       = adr_q;
        size_d      = size_q;
        we_d        = we_q;
        instr_d     = instr_q;
        d_d         = d_q;
        flushed_d   = flushed_q;
        done_d      = 1'b0;
        cause_d     = cause_q;
        fault_adr_d = fault_adr_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    adr_d     = adr_i;
                    size_d    = size_i;
                    we_d      = we_i;
                    instr_d   = instruction_i;
                    d_d       = d_i;
                    flushed_d = 1'b0;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                // A flush outranks the verdict: the access simply vanishes.
                if (flush_i) begin
                    state_d = IDLE;
                end else if (pmp_exception_i) begin
                    fault_adr_d = adr_q;
                    cause_d     = instr_q ? 4'd1 : (we_q ? 4'd7 : 4'd5);
                    state_d     = FAULT;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The BIU request cannot be withdrawn once raised; a flush
                // only suppresses the completion pulse of this access.
                if (flush_i) begin
                    flushed_d = 1'b1;
                end
                if (biu_ack_i) begin
                    done_d  = !(flushed_q || flush_i);
                    state_d = IDLE;
                end
            end
            FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the holding registers sit on the asynchronous reset too, so the
    // BIU and trap-value outputs come out of reset at a defined zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            size_q      <= BYTE;
            we_q        <= 1'b0;
            instr_q     <= 1'b0;
            d_q         <= '0;
            flushed_q   <= 1'b0;
            done_q      <= 1'b0;
            cause_q     <= '0;
            fault_adr_q <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            instr_q     <= instr_d;
            d_q         <= d_d;
            flushed_q   <= flushed_d;
            done_q      <= done_d;
            cause_q     <= cause_d;
            fault_adr_q <= fault_adr_d;
        end
    end

    // In IDLE the request goes straight through so the checker sees it in
    // the accept cycle; afterwards the checker is frozen on the held copy.
    always_comb begin
        if (state_q == IDLE) begin
            pmp_adr_o         = adr_i;
            pmp_size_o        = size_i;
            pmp_we_o          = we_i;
            pmp_instruction_o = instruction_i;
        end else begin
            pmp_adr_o         = adr_q;
            pmp_size_o        = size_q;
            pmp_we_o          = we_q;
            pmp_instruction_o = instr_q;
        end
    end

    assign pmp_stall_o   = (state_q != IDLE);

    assign biu_req_o     = (state_q == ISSUE);
    assign biu_adr_o     = adr_q;
    assign biu_size_o    = size_q;
    assign biu_we_o      = we_q;
    assign biu_d_o       = d_q;

    assign done_o        = done_q;
    assign fault_o       = (state_q == FAULT);
    assign fault_cause_o = cause_q;
    assign fault_adr_o   = fault_adr_q;

endmodule

// File: tb/tb_riscv_pmp_access_gate.sv
// ---------------------------------------------------------------------------
// tb_riscv_pmp_access_gate
//
// Directed stimulus for riscv_pmp_access_gate. Each access pushes its
// expected BIU handshake, completion pulse or fault into a queue; a monitor
// running on the falling clock edge pops and compares whenever the gate
// hands an access to the BIU, pulses done_o or pulses fault_o. Latency,
// stability and reset behaviour are checked inline by the driver.
// ---------------------------------------------------------------------------
module tb_riscv_pmp_access_gate;
    import riscv_pmp_pkg::*;

    localparam int XLEN = 32;
    localparam int PLEN = 34;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            req_i = 1'b0;
    logic [PLEN-1:0] adr_i = '0;
    biu_size_t       size_i = WORD;
    logic            we_i = 1'b0;
    logic            instruction_i = 1'b0;
    logic [XLEN-1:0] d_i = '0;
    logic            ack_o;
    logic [PLEN-1:0] pmp_adr_o;
    biu_size_t       pmp_size_o;
    logic            pmp_we_o;
    logic            pmp_instruction_o;
    logic            pmp_stall_o;
    logic            pmp_exception_i = 1'b0;
    logic            biu_req_o;
    logic [PLEN-1:0] biu_adr_o;
    biu_size_t       biu_size_o;
    logic            biu_we_o;
    logic [XLEN-1:0] biu_d_o;
    logic            biu_ack_i = 1'b0;
    logic            done_o;
    logic            fault_o;
    logic [3:0]      fault_cause_o;
    logic [PLEN-1:0] fault_adr_o;

    riscv_pmp_access_gate #(.XLEN(XLEN), .PLEN(PLEN)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .req_i             (req_i),
        .adr_i             (adr_i),
        .size_i            (size_i),
        .we_i              (we_i),
        .instruction_i     (instruction_i),
        .d_i               (d_i),
        .ack_o             (ack_o),
        .pmp_adr_o         (pmp_adr_o),
        .pmp_size_o        (pmp_size_o),
        .pmp_we_o          (pmp_we_o),
        .pmp_instruction_o (pmp_instruction_o),
        .pmp_stall_o       (pmp_stall_o),
        .pmp_exception_i   (pmp_exception_i),
        .biu_req_o         (biu_req_o),
        .biu_adr_o         (biu_adr_o),
        .biu_size_o        (biu_size_o),
        .biu_we_o          (biu_we_o),
        .biu_d_o           (biu_d_o),
        .biu_ack_i         (biu_ack_i),
        .done_o            (done_o),
        .fault_o           (fault_o),
        .fault_cause_o     (fault_cause_o),
        .fault_adr_o       (fault_adr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int {EV_BIU = 0, EV_DONE = 1, EV_FAULT = 2} ev_kind_e;

    typedef struct {
        ev_kind_e        kind;
        logic [PLEN-1:0] adr;
        biu_size_t       size;
        logic            we;
        logic [XLEN-1:0] d;
        logic [3:0]      cause;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pops the oldest expectation; an empty queue means the gate produced an
    // event nobody asked for.
    task automatic pop_expect(input string name, output ev_t e, output bit ok);
        n_cmp++;
        ok = (sb.size() != 0);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got unexpected event, expected none pending (t=%0t)", name, $time);
            e = '{EV_BIU, '0, BYTE, 1'b0, '0, '0};
        end else begin
            e = sb.pop_front();
        end
    endtask

    function automatic void push_biu(input logic [PLEN-1:0] adr, input biu_size_t size,
                                     input logic we, input logic [XLEN-1:0] d,
                                     input bit with_done);
        sb.push_back('{EV_BIU, adr, size, we, d, 4'd0});
        if (with_done) sb.push_back('{EV_DONE, adr, size, we, d, 4'd0});
    endfunction

    function automatic void push_fault(input logic [PLEN-1:0] adr, input logic [3:0] cause);
        sb.push_back('{EV_FAULT, adr, WORD, 1'b0, '0, cause});
    endfunction

    // Monitor: decoupled from the driver, samples on the falling edge.
    ev_t mon_e;
    bit  mon_ok;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (biu_req_o && biu_ack_i) begin
                pop_expect("sb_biu", mon_e, mon_ok);
                if (mon_ok) begin
                    check("sb_biu_kind", mon_e.kind, EV_BIU);
                    check("sb_biu_adr", biu_adr_o, mon_e.adr);
                    check("sb_biu_size", biu_size_o, mon_e.size);
                    check("sb_biu_we", biu_we_o, mon_e.we);
                    check("sb_biu_d", biu_d_o, mon_e.d);
                end
            end
            if (done_o) begin
                pop_expect("sb_done", mon_e, mon_ok);
                if (mon_ok) check("sb_done_kind", mon_e.kind, EV_DONE);
            end
            if (fault_o) begin
                pop_expect("sb_fault", mon_e, mon_ok);
                if (mon_ok) begin
                    check("sb_fault_kind", mon_e.kind, EV_FAULT);
                    check("sb_fault_cause", fault_cause_o, mon_e.cause);
                    check("sb_fault_adr", fault_adr_o, mon_e.adr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drives a request in an IDLE cycle, checks it is accepted and passed
    // through to the checker, and returns 1 ns after the accepting edge
    // (first CHECK cycle) with inputs scrambled to prove the gate holds.
    task automatic present(input logic [PLEN-1:0] adr, input biu_size_t size,
                           input logic we, input logic instr, input logic [XLEN-1:0] d);
        req_i         = 1'b1;
        adr_i         = adr;
        size_i        = size;
        we_i          = we;
        instruction_i = instr;
        d_i           = d;
        #1;
        check("accept_ack", ack_o, 1'b1);
        check("idle_pmp_passthru", {pmp_adr_o, pmp_size_o, pmp_we_o, pmp_instruction_o},
              {adr, size, we, instr});
        step();
        req_i         = 1'b0;
        adr_i         = ~adr;
        we_i          = ~we;
        instruction_i = ~instr;
        d_i           = ~d;
        #1;
        check("check_stall_hold", {pmp_stall_o, ack_o, pmp_adr_o, pmp_we_o, pmp_instruction_o},
              {1'b1, 1'b0, adr, we, instr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values ----------------
        #12;
        check("rst_ack", ack_o, 1'b1);
        check("rst_ctrl", {biu_req_o, done_o, fault_o, pmp_stall_o}, 4'b0000);
        check("rst_cause", fault_cause_o, 4'd0);
        check("rst_data", {fault_adr_o, biu_adr_o, biu_d_o, biu_we_o}, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // ---------------- clean load ----------------
        push_biu(34'h0_0000_1000, WORD, 1'b0, 32'h0, 1'b1);
        present(34'h0_0000_1000, WORD, 1'b0, 1'b0, 32'h0);
        pmp_exception_i = 1'b0;
        step();                                              // cycle 2
        check("load_biu_req_c2", {biu_req_o, biu_adr_o}, {1'b1, 34'h0_0000_1000});
        check("load_no_fault", fault_o, 1'b0);
        step();                                              // cycle 3
        biu_ack_i = 1'b1;
        step();                                              // cycle 4
        biu_ack_i = 1'b0;
        check("load_done_c4", {done_o, biu_req_o, ack_o}, 3'b101);
        step();
        check("load_done_one_pulse", done_o, 1'b0);

        // ---------------- store fault ----------------
        push_fault(34'h2_0000_0004, 4'd7);
        present(34'h2_0000_0004, WORD, 1'b1, 1'b0, 32'hCAFE_0001);
        pmp_exception_i = 1'b1;
        step();                                              // cycle 2
        pmp_exception_i = 1'b0;
        check("store_fault_c2", {fault_o, biu_req_o}, 2'b10);
        check("store_fault_cause", fault_cause_o, 4'd7);
        step();
        check("store_fault_one_pulse", {fault_o, biu_req_o, ack_o}, 3'b001);
        check("store_fault_hold", {fault_cause_o, fault_adr_o}, {4'd7, 34'h2_0000_0004});

        // ---------------- fetch fault / load fault ----------------
        push_fault(34'h0_8000_0000, 4'd1);
        present(34'h0_8000_0000, WORD, 1'b0, 1'b1, 32'h0);
        pmp_exception_i = 1'b1;
        step();
        pmp_exception_i = 1'b0;
        check("fetch_fault_cause", fault_cause_o, 4'd1);
        step();

        push_fault(34'h1_2345_6788, 4'd5);
        present(34'h1_2345_6788, HWORD, 1'b0, 1'b0, 32'h0);
        pmp_exception_i = 1'b1;
        step();
        pmp_exception_i = 1'b0;
        check("load_fault_cause", fault_cause_o, 4'd5);
        step();

        // ---------------- BIU backpressure ----------------
        push_biu(34'h3_0000_0010, BYTE, 1'b1, 32'hDEAD_BEEF, 1'b1);
        present(34'h3_0000_0010, BYTE, 1'b1, 1'b0, 32'hDEAD_BEEF);
        step();                                              // ISSUE
        for (int i = 0; i < 5; i++) begin
            check("bp_stable", {biu_req_o, ack_o, pmp_stall_o, biu_adr_o, biu_d_o, biu_we_o, biu_size_o},
                  {1'b1, 1'b0, 1'b1, 34'h3_0000_0010, 32'hDEAD_BEEF, 1'b1, BYTE});
            step();
        end
        biu_ack_i = 1'b1;
        step();
        biu_ack_i = 1'b0;
        check("bp_done", done_o, 1'b1);
        check("cause_held_after_clean", {fault_cause_o, fault_adr_o}, {4'd5, 34'h1_2345_6788});
        step();

        // ---------------- flush in CHECK beats a fault verdict ----------------
        present(34'h0_0000_4000, WORD, 1'b0, 1'b0, 32'h0);
        flush_i         = 1'b1;
        pmp_exception_i = 1'b1;
        step();
        flush_i         = 1'b0;
        pmp_exception_i = 1'b0;
        #1;
        check("flush_check_idle", {ack_o, pmp_stall_o, biu_req_o, fault_o}, 4'b1000);
        step();
        check("flush_check_no_fault", {fault_o, biu_req_o, done_o}, 3'b000);

        // ---------------- flush in ISSUE ----------------
        push_biu(34'h0_0000_5000, HWORD, 1'b1, 32'h1234_5678, 1'b0);
        present(34'h0_0000_5000, HWORD, 1'b1, 1'b0, 32'h1234_5678);
        step();                                              // ISSUE
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_issue_req_held", {biu_req_o, biu_adr_o}, {1'b1, 34'h0_0000_5000});
        step();
        check("flush_issue_req_held2", biu_req_o, 1'b1);
        biu_ack_i = 1'b1;
        step();
        biu_ack_i = 1'b0;
        check("flush_issue_no_done", {done_o, biu_req_o, ack_o}, 3'b001);
        step();

        // ---------------- back-to-back, same-cycle BIU ack ----------------
        push_biu(34'h0_0000_6000, WORD, 1'b0, 32'h0, 1'b1);
        push_biu(34'h1_0000_6004, DWORD, 1'b1, 32'h0BAD_F00D, 1'b1);
        present(34'h0_0000_6000, WORD, 1'b0, 1'b0, 32'h0);
        step();                                              // ISSUE
        biu_ack_i = 1'b1;
        step();                                              // IDLE, done for first
        biu_ack_i = 1'b0;
        check("b2b_done_first", done_o, 1'b1);
        present(34'h1_0000_6004, DWORD, 1'b1, 1'b0, 32'h0BAD_F00D);
        step();                                              // ISSUE
        biu_ack_i = 1'b1;
        step();
        biu_ack_i = 1'b0;
        check("b2b_done_second", done_o, 1'b1);
        step();

        // ---------------- req with flush in IDLE, stray BIU ack ----------------
        req_i     = 1'b1;
        flush_i   = 1'b1;
        biu_ack_i = 1'b1;
        adr_i     = 34'h0_0000_7000;
        #1;
        check("idle_flush_no_ack", ack_o, 1'b0);
        step();
        req_i     = 1'b0;
        flush_i   = 1'b0;
        biu_ack_i = 1'b0;
        #1;
        check("idle_flush_stays_idle", {pmp_stall_o, biu_req_o, ack_o}, 3'b001);
        step();
        check("stray_ack_no_done", done_o, 1'b0);

        // ---------------- async reset during ISSUE ----------------
        present(34'h0_0000_8000, WORD, 1'b1, 1'b0, 32'h5555_AAAA);
        step();                                              // ISSUE
        check("pre_reset_req", biu_req_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("reset_drops_req", {biu_req_o, ack_o, pmp_stall_o, done_o, fault_o}, 5'b01000);
        check("reset_clears_regs", {fault_cause_o, fault_adr_o, biu_adr_o, biu_d_o}, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        push_biu(34'h0_0000_9000, WORD, 1'b0, 32'h0, 1'b1);
        present(34'h0_0000_9000, WORD, 1'b0, 1'b0, 32'h0);
        step();
        check("post_reset_issue", {biu_req_o, biu_adr_o}, {1'b1, 34'h0_0000_9000});
        biu_ack_i = 1'b1;
        step();
        biu_ack_i = 1'b0;
        check("post_reset_done", done_o, 1'b1);
        step();
        step();

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
